// File: rtl/pixmem_arbiter.sv
// Single-port sprite RAM arbiter: display reads always win, then the clear engine, then edits.
// Edit toggles are read-modify-write; edit_ack is held off until the requester drops edit_req.
module pixmem_arbiter #(
  parameter int                 DATA_W    = 1,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
  input  logic              vgaclk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [7:0]        disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              edit_req,
  input  logic              edit_toggle,
  input  logic [7:0]        edit_addr,
  input  logic [DATA_W-1:0] edit_wdata,
  output logic              edit_ack,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [7:0]        mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_TOG_CAP, S_TOG_WR, S_ACK_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] tog_q, tog_d;
  logic              disp_valid_q;
  logic              edit_ack_q, edit_ack_d;
  logic              clear_busy_q;
  logic              clear_done_q, clear_done_d;

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tog_q        <= '0;
      disp_valid_q <= 1'b0;
      edit_ack_q   <= 1'b0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tog_q        <= tog_d;
      disp_valid_q <= disp_req;
      edit_ack_q   <= edit_ack_d;
      clear_busy_q <= (state_d == S_CLEAR);
      clear_done_q <= clear_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tog_d        = tog_q;
    edit_ack_d   = 1'b0;
    clear_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear_start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (edit_req && !disp_req) begin
          if (edit_toggle) begin
            state_d = S_TOG_CAP;
          end else begin
            state_d    = S_ACK_HOLD;
            edit_ack_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (!disp_req) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'hFF) begin
            state_d      = S_IDLE;
            clear_done_d = 1'b1;
          end
        end
      end
      // mem_rdata here belongs to the edit read issued from IDLE.
      S_TOG_CAP: begin
        tog_d   = mem_rdata;
        state_d = S_TOG_WR;
      end
      S_TOG_WR: begin
        if (!disp_req) begin
          state_d    = S_ACK_HOLD;
          edit_ack_d = 1'b1;
        end
      end
      S_ACK_HOLD: begin
        if (!edit_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (disp_req) begin
      mem_addr = disp_addr;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!clear_start && edit_req) begin
            mem_addr  = edit_addr;
            mem_we    = !edit_toggle;
            mem_wdata = edit_wdata;
          end
        end
        S_CLEAR: begin
          mem_addr  = cnt_q;
          mem_we    = 1'b1;
          mem_wdata = CLEAR_VAL;
        end
        S_TOG_WR: begin
          mem_addr  = edit_addr;
          mem_we    = 1'b1;
          mem_wdata = ~tog_q;
        end
        default: ;
      endcase
    end
  end

  // The RAM output register acts as the display data register.
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_valid_q ? mem_rdata : '0;
  assign edit_ack   = edit_ack_q;
  assign clear_busy = clear_busy_q;
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_pixmem_arbiter.sv
// Scoreboarded bench for pixmem_arbiter with a registered-read 256x1 RAM model.
module tb_pixmem_arbiter;
  localparam int DW = 1;

  logic          vgaclk = 1'b0;
  logic          reset = 1'b1;
  logic          disp_req = 1'b0;
  logic [7:0]    disp_addr = '0;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          edit_req = 1'b0;
  logic          edit_toggle = 1'b0;
  logic [7:0]    edit_addr = '0;
  logic [DW-1:0] edit_wdata = '0;
  logic          edit_ack;
  logic          clear_start = 1'b0;
  logic          clear_busy;
  logic          clear_done;
  logic [7:0]    mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram [256];

  typedef struct {
    logic [7:0]    a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wq[$];
  logic [DW-1:0] dq[$];
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 vgaclk = ~vgaclk;

  pixmem_arbiter #(.DATA_W(DW), .CLEAR_VAL('0)) dut (
    .vgaclk(vgaclk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .edit_req(edit_req), .edit_toggle(edit_toggle),
    .edit_addr(edit_addr), .edit_wdata(edit_wdata), .edit_ack(edit_ack),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge vgaclk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_wr(input int a, input int d);
    wr_t w;
    w.a = a[7:0];
    w.d = d[DW-1:0];
    wq.push_back(w);
  endtask

  // Monitor: pops expectations whenever the DUT shows a display result or a RAM write.
  logic          prev_req = 1'b0;
  logic          prev_rst = 1'b1;
  wr_t           mw;
  logic [DW-1:0] md;
  always @(negedge vgaclk) begin
    if (!reset) begin
      chk("disp_valid_timing", int'(disp_valid), int'(prev_req && !prev_rst));
      if (disp_valid) begin
        if (dq.size() == 0) chk("disp_unexpected", 1, 0);
        else begin
          md = dq.pop_front();
          chk("disp_data", int'(disp_data), int'(md));
        end
      end
      if (mem_we) begin
        if (wq.size() == 0) chk("wr_unexpected", int'(mem_addr), -1);
        else begin
          mw = wq.pop_front();
          chk("wr_addr", int'(mem_addr), int'(mw.a));
          chk("wr_data", int'(mem_wdata), int'(mw.d));
        end
      end
    end
    prev_req = disp_req;
    prev_rst = reset;
  end

  task automatic tick();
    @(posedge vgaclk);
    #1;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge vgaclk);
      n++;
      if (edit_ack) break;
    end
  endtask

  task automatic do_write(input int a, input int d);
    int n;
    push_wr(a, d);
    edit_req = 1'b1; edit_toggle = 1'b0;
    edit_addr = a[7:0]; edit_wdata = d[DW-1:0];
    wait_ack(n);
    chk("write_ack_latency", n, 2);
    tick();
    edit_req = 1'b0;
    tick();
  endtask

  task automatic run_clear(input int nd_lo, input int nd_hi, input bit with_edit,
                           input int restart_at, output int busy, output int done,
                           output int done_cyc, output int ack_cyc);
    busy = 0; done = 0; done_cyc = -1; ack_cyc = -1;
    for (int k = 0; k < 256; k++) push_wr(k, 0);
    if (with_edit) push_wr(8'h33, 1);
    edit_toggle = 1'b0; edit_addr = 8'h33; edit_wdata = 1'b1;
    for (int i = 0; i < 320; i++) begin
      clear_start = (i == 0) || (i == restart_at);
      disp_req    = (i >= nd_lo) && (i < nd_hi);
      disp_addr   = 8'h00;
      if (disp_req) dq.push_back('0);
      edit_req    = with_edit && (ack_cyc < 0);
      @(negedge vgaclk);
      busy += int'(clear_busy);
      if (clear_done) begin done++; done_cyc = i; end
      if (edit_ack) ack_cyc = i;
      tick();
    end
    clear_start = 1'b0; disp_req = 1'b0; edit_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acks, busy, done, dcyc, acyc;

    repeat (3) tick();
    reset = 1'b0;
    @(negedge vgaclk);
    chk("rst_disp_valid", int'(disp_valid), 0);
    chk("rst_disp_data", int'(disp_data), 0);
    chk("rst_edit_ack", int'(edit_ack), 0);
    chk("rst_clear_busy", int'(clear_busy), 0);
    chk("rst_clear_done", int'(clear_done), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    tick();

    // Preload through plain edit writes.
    do_write(8'h00, 1);
    do_write(8'h11, 0);
    do_write(8'hFF, 1);
    do_write(8'h05, 0);

    // Display-only burst.
    disp_req = 1'b1; disp_addr = 8'h00; dq.push_back(1'b1); tick();
    disp_addr = 8'h11; dq.push_back(1'b0); tick();
    disp_addr = 8'hFF; dq.push_back(1'b1); tick();
    disp_req = 1'b0; tick(); tick();
    chk("disp_queue_drained", dq.size(), 0);

    // Plain write, request held after ack.
    push_wr(8'h2A, 1);
    edit_req = 1'b1; edit_toggle = 1'b0; edit_addr = 8'h2A; edit_wdata = 1'b1;
    wait_ack(n);
    chk("plain_ack_latency", n, 2);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge vgaclk);
      acks += int'(edit_ack);
    end
    chk("plain_no_second_ack", acks, 0);
    tick();
    edit_req = 1'b0; tick(); tick();

    // Toggle of 0x05 with display reads in the two cycles after the edit read.
    push_wr(8'h05, 1);
    edit_req = 1'b1; edit_toggle = 1'b1; edit_addr = 8'h05;
    tick();
    disp_req = 1'b1; disp_addr = 8'h00; dq.push_back(1'b1); tick();
    disp_addr = 8'h2A; dq.push_back(1'b1); tick();
    disp_req = 1'b0;
    wait_ack(n);
    chk("toggle_ack_latency", n, 2);
    tick();
    edit_req = 1'b0; edit_toggle = 1'b0; tick();
    disp_req = 1'b1; disp_addr = 8'h05; dq.push_back(1'b1); tick();
    disp_req = 1'b0; tick(); tick();
    chk("toggle_writes_drained", wq.size(), 0);

    // Clear without traffic, with an ignored clear_start at cycle 50.
    run_clear(0, 0, 1'b0, 50, busy, done, dcyc, acyc);
    chk("clear_busy_cycles", busy, 256);
    chk("clear_done_pulses", done, 1);
    chk("clear_done_cycle", dcyc, 257);
    chk("clear_writes_drained", wq.size(), 0);

    // Clear with 10 display cycles.
    run_clear(20, 30, 1'b0, -1, busy, done, dcyc, acyc);
    chk("clear_disp_busy_cycles", busy, 266);
    chk("clear_disp_done_pulses", done, 1);
    chk("clear_disp_done_cycle", dcyc, 267);

    // clear_start and edit_req together: clear first, edit right after clear_done.
    run_clear(0, 0, 1'b1, 50, busy, done, dcyc, acyc);
    chk("collide_busy_cycles", busy, 256);
    chk("collide_done_pulses", done, 1);
    chk("collide_ack_after_done", acyc - dcyc, 1);
    chk("collide_writes_drained", wq.size(), 0);

    // Reset while cnt=100.
    for (int k = 0; k < 100; k++) push_wr(k, 0);
    clear_start = 1'b1; tick();
    clear_start = 1'b0;
    repeat (100) tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    @(negedge vgaclk);
    chk("abort_clear_busy", int'(clear_busy), 0);
    chk("abort_writes_consumed", wq.size(), 0);
    done = 0;
    for (int i = 0; i < 8; i++) begin
      done += int'(clear_done);
      @(negedge vgaclk);
    end
    chk("abort_no_done", done, 0);
    tick();
    run_clear(0, 0, 1'b0, -1, busy, done, dcyc, acyc);
    chk("restart_busy_cycles", busy, 256);
    chk("restart_done_pulses", done, 1);

    tick(); tick();
    chk("final_disp_queue", dq.size(), 0);
    chk("final_write_queue", wq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
